bldc_commutation_ctrl: RTL and testbench
========================================

# bldc_commutation_ctrl

Six-step commutation sequencer for the flywheel BLDC drive. It filters the three Hall inputs and selects the active phase pair from the filtered Hall state and the commanded direction. It inserts dead time on every pattern change, gates the high sides with the PWM carrier, and latches faults on an invalid Hall code or a stalled rotor. It sits between the Hall pins, the PWM generator and the gate-driver outputs, alongside the speed-direction estimator.

## Interface
- DEAD_CYC, 8: all-gates-off cycles inserted before any new drive pattern (1..255).
- FILT_LEN, 4: consecutive identical synchronized samples required to accept a Hall code (2..15).
- STALL_CYC, 1000000: clk cycles without a Hall change in DRIVE/DEADTIME before a stall fault (24-bit).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- hall_a, hall_b, hall_c  in  1 each  raw Hall sensor pins, asynchronous
- run_en  in  1  level; 1 = drive motor
- dir_cmd  in  1  0 = forward, 1 = reverse
- pwm_in  in  1  PWM carrier from the PWM generator
- fault_clr  in  1  one-cycle pulse; clears a latched fault
- gate  out  6  {AH,AL,BH,BL,CH,CL}, registered, 1 = switch on
- fault  out  1  latched fault flag
- fault_code  out  2  01 invalid Hall, 10 stall, 00 none
- comm_cnt  out  16  commutation counter, wraps at 0xFFFF -> 0

## Operation
- Hall code is {hall_c,hall_b,hall_a}, passed through a 2-flop synchronizer.
- hall_f takes a new value once FILT_LEN consecutive synchronized samples agree. hall_f resets to 000.
- Forward sequence is 101->100->110->010->011->001->101.
- Forward pattern, written high+/low-:
  - 101: A+B-
  - 100: A+C-
  - 110: B+C-
  - 010: B+A-
  - 011: C+A-
  - 001: C+B-
- Reverse (dir_cmd=1) swaps the high and low phase of each entry. For example, 101 becomes B+A-.
- In DRIVE, the selected high-side bit equals pwm_in registered, and the selected low-side bit is held at 1. All other bits are 0.
- An AH/AL pair (or BH/BL, CH/CL) is never 1 in the same cycle.
- FSM states: IDLE, DEADTIME, DRIVE, FAULT.
- IDLE:
  - gate=0.
  - run_en=1 with hall_f valid (not 000/111): go to DEADTIME and load the pattern.
  - run_en=1 with hall_f 000/111 after the filter has accepted a code: go to FAULT with code 01.
- DEADTIME:
  - gate=0, and the dead counter counts to DEAD_CYC, then the FSM goes to DRIVE.
  - A hall_f or dir_cmd change reloads the pattern and restarts the count.
- DRIVE:
  - A valid hall_f change or a dir_cmd change goes to DEADTIME with the new pattern.
  - A hall_f change also increments comm_cnt.
- Any state except FAULT: run_en=0 returns the FSM to IDLE.
- DEADTIME/DRIVE fault checks:
  - hall_f becoming 000/111 -> FAULT, code 01.
  - Stall counter reaching STALL_CYC -> FAULT, code 10.
  - When both occur in the same cycle, code 01 takes priority.
- Stall counter: cleared on any hall_f change and held at 0 in IDLE. It increments in DEADTIME/DRIVE.
- FAULT: gate=0 and fault=1. Leave to IDLE only on fault_clr=1 with run_en=0, which clears fault and fault_code. Otherwise the fault stays latched.
- Reset values: gate=0, fault=0, fault_code=00, comm_cnt=0, FSM=IDLE. Reset asserted mid-drive forces gate=0 asynchronously.

## Timing
- Hall pin change held stable -> hall_f update: 2+FILT_LEN cycles.
- hall_f change in DRIVE -> gate=0 on the next clk edge. The new pattern appears DEAD_CYC cycles after that.
- pwm_in -> high-side gate bit: 1 cycle.
- run_en falling -> gate=0: 1 cycle.
- Fault condition -> fault=1 and gate=0: 1 cycle.
- comm_cnt increments in the same cycle the FSM enters DEADTIME because of a Hall change.

## Test plan
- Power-up with Hall 101, dir_cmd=0, run_en=1, pwm_in=1 -> gate=000000 for DEAD_CYC=8 cycles, then 100100 (AH, BL).
- Forward rotation through all 6 codes -> each step gives an 8-cycle all-off gap then the table pattern; comm_cnt=6 after one electrical turn. Repeat with dir_cmd=1 and check the swapped patterns (101 -> 011000).
- 3-cycle Hall glitch with FILT_LEN=4 -> hall_f unchanged, gate unchanged, comm_cnt unchanged.
- Hall forced to 111 in DRIVE -> fault=1, fault_code=01, gate=0. fault_clr with run_en=1 is ignored; with run_en=0 the FSM returns to IDLE.
- Hall frozen with STALL_CYC=100 -> fault_code=10 exactly at stall count 100. A dir_cmd toggle mid-DRIVE produces a full dead-time gap then the reversed pattern.
- pwm_in toggling during DRIVE -> high-side bit follows with 1-cycle delay and the low side stays on. rst_n pulsed low mid-DRIVE -> gate=0 immediately and all outputs return to their reset values.

Source files
------------

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer: Hall filtering, dead-time insertion,
// PWM-gated high sides and latched invalid-Hall / stall faults.
module bldc_commutation_ctrl #(
  parameter int unsigned DEAD_CYC  = 8,
  parameter int unsigned FILT_LEN  = 4,
  parameter int unsigned STALL_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hall_a,
  input  logic        hall_b,
  input  logic        hall_c,
  input  logic        run_en,
  input  logic        dir_cmd,
  input  logic        pwm_in,
  input  logic        fault_clr,
  output logic [5:0]  gate,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] comm_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDead  = 2'd1;
  localparam logic [1:0] StDrive = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  localparam logic [3:0]  FiltLen   = 4'(FILT_LEN);
  localparam logic [7:0]  DeadLast  = 8'(DEAD_CYC - 1);
  localparam logic [23:0] StallLast = 24'(STALL_CYC - 1);

  logic [2:0]  hall_s1, hall_s2, hall_cand, hall_f;
  logic [3:0]  filt_cnt;
  logic        hall_seen;
  logic [1:0]  state_q, state_d;
  logic [2:0]  pat_hall;
  logic        pat_dir;
  logic [7:0]  dead_cnt;
  logic [23:0] stall_cnt;
  logic [1:0]  code_d;
  logic [5:0]  gate_d;
  logic        load, comm_inc;
  logic        hall_bad, hall_chg, dir_chg, stall_hit;
  logic [1:0]  hi_ph, lo_ph;
  logic [5:0]  hi_mask, lo_mask;

  // Synchronizer plus run-length filter; hall_seen marks that any code was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1   <= 3'b000;
      hall_s2   <= 3'b000;
      hall_cand <= 3'b000;
      hall_f    <= 3'b000;
      filt_cnt  <= 4'd0;
      hall_seen <= 1'b0;
    end else begin
      hall_s1 <= {hall_c, hall_b, hall_a};
      hall_s2 <= hall_s1;
      if (hall_s2 != hall_cand) begin
        hall_cand <= hall_s2;
        filt_cnt  <= 4'd1;
      end else if (filt_cnt < FiltLen) begin
        filt_cnt <= filt_cnt + 4'd1;
        if (filt_cnt + 4'd1 == FiltLen) begin
          hall_f    <= hall_cand;
          hall_seen <= 1'b1;
        end
      end
    end
  end

  assign hall_bad  = (hall_f == 3'b000) || (hall_f == 3'b111);
  assign hall_chg  = (hall_f != pat_hall);
  assign dir_chg   = (dir_cmd != pat_dir);
  assign stall_hit = !hall_chg && (stall_cnt == StallLast);

  // Phase index 0=A, 1=B, 2=C; reverse swaps the high and low phase.
  always_comb begin
    hi_ph = 2'd0;
    lo_ph = 2'd1;
    case (pat_hall)
      3'b101:  begin hi_ph = 2'd0; lo_ph = 2'd1; end
      3'b100:  begin hi_ph = 2'd0; lo_ph = 2'd2; end
      3'b110:  begin hi_ph = 2'd1; lo_ph = 2'd2; end
      3'b010:  begin hi_ph = 2'd1; lo_ph = 2'd0; end
      3'b011:  begin hi_ph = 2'd2; lo_ph = 2'd0; end
      3'b001:  begin hi_ph = 2'd2; lo_ph = 2'd1; end
      default: begin hi_ph = 2'd0; lo_ph = 2'd1; end
    endcase
    if (pat_dir) {hi_ph, lo_ph} = {lo_ph, hi_ph};
    hi_mask = 6'b100000 >> {hi_ph, 1'b0};
    lo_mask = 6'b010000 >> {lo_ph, 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    code_d   = fault_code;
    load     = 1'b0;
    comm_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_en && !hall_bad) begin
          state_d = StDead;
          load    = 1'b1;
        end else if (run_en && hall_seen) begin
          state_d = StFault;
          code_d  = 2'b01;
        end
      end
      StDead, StDrive: begin
        if (!run_en) begin
          state_d = StIdle;
        end else if (hall_bad) begin
          state_d = StFault;
          code_d  = 2'b01;
        end else if (stall_hit) begin
          state_d = StFault;
          code_d  = 2'b10;
        end else if (hall_chg || dir_chg) begin
          state_d  = StDead;
          load     = 1'b1;
          comm_inc = (state_q == StDrive) && hall_chg;
        end else if ((state_q == StDead) && (dead_cnt == DeadLast)) begin
          state_d = StDrive;
        end
      end
      StFault: begin
        if (fault_clr && !run_en) begin
          state_d = StIdle;
          code_d  = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
    gate_d = 6'b000000;
    if (state_d == StDrive) gate_d = lo_mask | (pwm_in ? hi_mask : 6'b000000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pat_hall   <= 3'b000;
      pat_dir    <= 1'b0;
      dead_cnt   <= 8'd0;
      stall_cnt  <= 24'd0;
      comm_cnt   <= 16'd0;
      fault_code <= 2'b00;
      gate       <= 6'b000000;
    end else begin
      state_q    <= state_d;
      fault_code <= code_d;
      gate       <= gate_d;
      if (load) begin
        pat_hall <= hall_f;
        pat_dir  <= dir_cmd;
        dead_cnt <= 8'd0;
      end else if (state_q == StDead) begin
        dead_cnt <= dead_cnt + 8'd1;
      end
      if (((state_q == StDead) || (state_q == StDrive)) && !hall_chg) begin
        stall_cnt <= stall_cnt + 24'd1;
      end else begin
        stall_cnt <= 24'd0;
      end
      if (comm_inc) comm_cnt <= comm_cnt + 16'd1;
    end
  end

  assign fault = (state_q == StFault);

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Bench for bldc_commutation_ctrl: table-driven commutation steps, hand-written
// fault/reset sequences and a randomized run against a history-based model.
module tb_bldc_commutation_ctrl;

  localparam int Dead  = 8;
  localparam int Filt  = 4;
  localparam int Stall = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hall_a = 1'b0, hall_b = 1'b0, hall_c = 1'b0;
  logic        run_en = 1'b0, dir_cmd = 1'b0, pwm_in = 1'b0, fault_clr = 1'b0;
  logic [5:0]  gate;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] comm_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bldc_commutation_ctrl #(
    .DEAD_CYC (Dead),
    .FILT_LEN (Filt),
    .STALL_CYC(Stall)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hall_a    (hall_a),
    .hall_b    (hall_b),
    .hall_c    (hall_c),
    .run_en    (run_en),
    .dir_cmd   (dir_cmd),
    .pwm_in    (pwm_in),
    .fault_clr (fault_clr),
    .gate      (gate),
    .fault     (fault),
    .fault_code(fault_code),
    .comm_cnt  (comm_cnt)
  );

  typedef struct {
    logic [2:0] hall;
    logic       dir;
    logic [5:0] gate;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hall(input logic [2:0] h);
    {hall_c, hall_b, hall_a} = h;
  endtask

  // Expected drive pattern from the commutation table (phase 0=A, 1=B, 2=C).
  function automatic logic [5:0] pattern(input logic [2:0] h, input logic d, input logic pwm);
    int hi, lo, t;
    logic [5:0] g;
    case (h)
      3'b101: begin hi = 0; lo = 1; end
      3'b100: begin hi = 0; lo = 2; end
      3'b110: begin hi = 1; lo = 2; end
      3'b010: begin hi = 1; lo = 0; end
      3'b011: begin hi = 2; lo = 0; end
      3'b001: begin hi = 2; lo = 1; end
      default: return 6'b000000;
    endcase
    if (d) begin t = hi; hi = lo; lo = t; end
    g = 6'b000000;
    g[5 - 2 * hi] = pwm;
    g[4 - 2 * lo] = 1'b1;
    return g;
  endfunction

  // One table step: old pattern holds through filtering, 8 dead cycles, new pattern.
  task automatic step_vec(input int i, input logic [5:0] prev_exp);
    int zeros;
    dir_cmd = vecs[i].dir;
    set_hall(vecs[i].hall);
    repeat (6) tick();
    chk("hold_old", gate, prev_exp);
    zeros = 0;
    repeat (Dead) begin
      tick();
      if (gate == 6'b000000) zeros++;
    end
    chk("dead_gap", zeros, Dead);
    tick();
    chk("pattern", gate, vecs[i].gate);
    chk("comm_step", comm_cnt, i + 1);
  endtask

  // Reference model state for the randomized run.
  logic [2:0] p_q[$];
  logic [2:0] hf_1, hf_2;
  logic       dir_prev;
  logic       started;
  int         n_edge, last_event, comm_m;

  task automatic cyc();
    logic [2:0] pins, hf_new;
    logic       ev_h, ev_d, same;
    logic [5:0] exp_gate;
    int         last;
    pins = {hall_c, hall_b, hall_a};
    tick();
    n_edge++;
    ev_h = (hf_1 != hf_2);
    ev_d = started && (dir_cmd != dir_prev);
    if (ev_h || ev_d) begin
      if (started && ev_h && (n_edge - 1 - last_event >= Dead)) comm_m++;
      started    = 1'b1;
      last_event = n_edge;
    end
    dir_prev = dir_cmd;
    p_q.push_back(pins);
    if (p_q.size() > 10) void'(p_q.pop_front());
    last = p_q.size() - 1;
    same = 1'b1;
    for (int k = 3; k <= Filt + 1; k++) if (p_q[last - k] != p_q[last - 2]) same = 1'b0;
    hf_new = same ? p_q[last - 2] : hf_1;
    hf_2 = hf_1;
    hf_1 = hf_new;
    exp_gate = (started && (n_edge - last_event >= Dead)) ? pattern(hf_2, dir_cmd, pwm_in)
                                                         : 6'b000000;
    chk("rand_gate", gate, exp_gate);
    chk("rand_comm", comm_cnt, comm_m);
    chk("rand_fault", fault, 1'b0);
  endtask

  initial begin
    logic [2:0] codes[6];
    logic [2:0] cur, nxt;
    logic [5:0] exp_g;
    int zeros, ok_cnt, hold;

    vecs[0]  = '{3'b100, 1'b0, 6'b100001};
    vecs[1]  = '{3'b110, 1'b0, 6'b001001};
    vecs[2]  = '{3'b010, 1'b0, 6'b011000};
    vecs[3]  = '{3'b011, 1'b0, 6'b010010};
    vecs[4]  = '{3'b001, 1'b0, 6'b000110};
    vecs[5]  = '{3'b101, 1'b0, 6'b100100};
    vecs[6]  = '{3'b001, 1'b1, 6'b001001};
    vecs[7]  = '{3'b011, 1'b1, 6'b100001};
    vecs[8]  = '{3'b010, 1'b1, 6'b100100};
    vecs[9]  = '{3'b110, 1'b1, 6'b000110};
    vecs[10] = '{3'b100, 1'b1, 6'b010010};
    vecs[11] = '{3'b101, 1'b1, 6'b011000};

    // Power-up with Hall 101, forward, PWM high.
    set_hall(3'b101);
    run_en = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gate", gate, 6'b000000);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", fault_code, 2'b00);
    chk("rst_comm", comm_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    repeat (14) begin
      tick();
      if (gate == 6'b000000) zeros++;
    end
    chk("pwrup_off", zeros, 14);
    tick();
    chk("pwrup_pat", gate, 6'b100100);
    chk("pwrup_comm", comm_cnt, 16'd0);

    for (int i = 0; i < 6; i++) step_vec(i, (i == 0) ? 6'b100100 : vecs[i - 1].gate);

    // Direction flip mid-drive: full dead gap then swapped pattern.
    dir_cmd = 1'b1;
    zeros = 0;
    repeat (Dead) begin
      tick();
      if (gate == 6'b000000) zeros++;
    end
    chk("dir_gap", zeros, Dead);
    tick();
    chk("dir_pat", gate, 6'b011000);
    chk("dir_comm", comm_cnt, 16'd6);

    for (int i = 6; i < 12; i++) step_vec(i, (i == 6) ? 6'b011000 : vecs[i - 1].gate);

    // PWM carrier passes to the high side with one cycle of delay.
    for (int k = 0; k < 20; k++) begin
      pwm_in = 1'($urandom_range(0, 1));
      exp_g = 6'b010000 | (pwm_in ? 6'b001000 : 6'b000000);
      tick();
      chk("pwm_follow", gate, exp_g);
    end
    pwm_in = 1'b1;
    tick();

    // Three-sample glitch must not reach hall_f.
    set_hall(3'b001);
    repeat (3) tick();
    set_hall(3'b101);
    ok_cnt = 0;
    repeat (12) begin
      tick();
      if (gate == 6'b011000) ok_cnt++;
    end
    chk("glitch_gate", ok_cnt, 12);
    chk("glitch_comm", comm_cnt, 16'd12);

    // Invalid Hall 111 while driving.
    set_hall(3'b111);
    repeat (6) tick();
    chk("inv_early", fault, 1'b0);
    tick();
    chk("inv_fault", fault, 1'b1);
    chk("inv_code", fault_code, 2'b01);
    chk("inv_gate", gate, 6'b000000);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick();
    chk("clr_run_fault", fault, 1'b1);
    chk("clr_run_code", fault_code, 2'b01);
    run_en = 1'b0;
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", fault, 1'b0);
    chk("clr_code", fault_code, 2'b00);
    chk("clr_gate", gate, 6'b000000);

    // Frozen Hall: stall fault after exactly Stall cycles of DEADTIME/DRIVE.
    set_hall(3'b101);
    dir_cmd = 1'b0;
    repeat (10) tick();
    run_en = 1'b1;
    repeat (Stall) tick();
    chk("stall_early", fault, 1'b0);
    tick();
    chk("stall_fault", fault, 1'b1);
    chk("stall_code", fault_code, 2'b10);
    chk("stall_gate", gate, 6'b000000);
    run_en = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("stall_clr", fault, 1'b0);

    // Asynchronous reset in the middle of DRIVE.
    run_en = 1'b1;
    repeat (Dead + 1) tick();
    chk("pre_reset", gate, 6'b100100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_gate", gate, 6'b000000);
    chk("areset_fault", fault, 1'b0);
    chk("areset_code", fault_code, 2'b00);
    chk("areset_comm", comm_cnt, 16'd0);

    // Randomized run against the model.
    codes[0] = 3'b101; codes[1] = 3'b100; codes[2] = 3'b110;
    codes[3] = 3'b010; codes[4] = 3'b011; codes[5] = 3'b001;
    cur = 3'b101;
    set_hall(cur);
    dir_cmd = 1'b0;
    pwm_in = 1'b0;
    run_en = 1'b1;
    p_q.delete();
    repeat (8) p_q.push_back(3'b000);
    hf_1 = 3'b000;
    hf_2 = 3'b000;
    dir_prev = 1'b0;
    started = 1'b0;
    n_edge = 0;
    last_event = -1000;
    comm_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      pwm_in = 1'($urandom_range(0, 1));
      cyc();
    end
    for (int s = 0; s < 40; s++) begin
      nxt = cur;
      while (nxt == cur) nxt = codes[$urandom_range(0, 5)];
      cur = nxt;
      set_hall(cur);
      hold = $urandom_range(4, 40);
      repeat (hold) begin
        pwm_in = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 29) == 0) dir_cmd = ~dir_cmd;
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
